bcd_sseg_ctrl: RTL and testbench

//   Downstream partner of the binary-to-BCD converter on the 3-digit 7-segment board.
//   - Issues periodic start requests to the converter and captures its 3 BCD digits on done_tick.
//   - Time-multiplexes the captured digits onto the common-anode display (active-low segments/anodes).
//   - Display is refreshed only from captured registers, so converter activity never glitches it.

---
 rtl/bcd_sseg_ctrl.sv | 139 +++++++++++++
 tb/tb_bcd_sseg_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sseg_ctrl.sv
// bcd_sseg_ctrl: requests BCD conversions periodically, captures the digits and scans them onto a 3-digit common-anode display (optional LEADING_ZERO_BLANK_EN blanks leading zeros)
module bcd_sseg_ctrl #(
    parameter int SAMPLE_PERIOD = 1048576,
    parameter int REFRESH_DIV   = 16384,
    parameter int WAIT_TIMEOUT  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic       done_tick,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic [2:0] dp_in,
    output logic       start,
    output logic       valid,
    output logic       timeout_err,
    output logic [7:0] seg_n,
    output logic [2:0] an_n
);
    localparam int SW = $clog2(SAMPLE_PERIOD);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int WW = $clog2(WAIT_TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] s_cnt;
    logic [RW-1:0] r_cnt;
    logic [WW-1:0] w_cnt;
    logic [3:0]    d2, d1, d0, dig;
    logic [1:0]    idx;
    logic          wrap, r_wrap, pending, go, cap, tmo, blank, dp;
    logic [6:0]    seg_g;
    logic [2:0]    an_nx;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    assign wrap   = s_cnt == SW'(SAMPLE_PERIOD - 1);
    assign r_wrap = r_cnt == RW'(REFRESH_DIV - 1);

    // Free-running sample timer; a wrap raises a request that survives until served
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s_cnt   <= '0;
            pending <= 1'b0;
        end else begin
            s_cnt   <= wrap ? '0 : s_cnt + SW'(1);
            pending <= wrap | (pending & ~go);
        end

    // FSM state register and WAIT cycle counter
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= S_IDLE;
            w_cnt <= '0;
        end else begin
            state <= state_nx;
            w_cnt <= (state == S_WAIT && state_nx == S_WAIT) ? w_cnt + WW'(1) : '0;
        end

    // FSM next state
    always_comb begin
        state_nx = go ? S_WAIT : (cap || tmo) ? S_IDLE : state;
    end

    // FSM outputs: the actions taken this cycle
    always_comb begin
        go  = (state == S_IDLE) && pending && ready;
        cap = (state == S_WAIT) && done_tick;
        tmo = (state == S_WAIT) && !done_tick && (w_cnt == WW'(WAIT_TIMEOUT - 1));
    end

    // Registered start pulse, capture registers and status flags
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            start       <= 1'b0;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            d2          <= '0;
            d1          <= '0;
            d0          <= '0;
        end else begin
            start       <= go;
            valid       <= valid | cap;
            timeout_err <= cap ? 1'b0 : tmo ? 1'b1 : timeout_err;
            d2          <= cap ? bcd2 : d2;
            d1          <= cap ? bcd1 : d1;
            d0          <= cap ? bcd0 : d0;
        end

    // Refresh divider stepping the digit index 0 -> 1 -> 2 -> 0
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_cnt <= '0;
            idx   <= '0;
        end else begin
            r_cnt <= r_wrap ? '0 : r_cnt + RW'(1);
            idx   <= r_wrap ? ((idx == 2'd2) ? 2'd0 : idx + 2'd1) : idx;
        end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = (idx == 2'd2 && d2 == 4'd0) || (idx == 2'd1 && d2 == 4'd0 && d1 == 4'd0);
`else
    assign blank = 1'b0;
`endif

    // Select the digit, decimal point and anode pattern for the current slot
    always_comb begin
        dig   = (idx == 2'd0) ? d0 : (idx == 2'd1) ? d1 : d2;
        dp    = (idx == 2'd0) ? dp_in[0] : (idx == 2'd1) ? dp_in[1] : dp_in[2];
        an_nx = (idx == 2'd0) ? 3'b110 : (idx == 2'd1) ? 3'b101 : 3'b011;
        seg_g = !valid ? 7'b0111111 : blank ? 7'b1111111 : seg_of(dig);
    end

    // Segments and anodes register together so the display switches cleanly
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            seg_n <= 8'hFF;
            an_n  <= 3'b111;
        end else begin
            seg_n <= {~dp, seg_g};
            an_n  <= an_nx;
        end
endmodule

// File: tb/tb_bcd_sseg_ctrl.sv
// tb_bcd_sseg_ctrl: scoreboard bench for bcd_sseg_ctrl with a simple converter model
module tb_bcd_sseg_ctrl;
    logic       clk = 1'b0, reset = 1'b1, ready = 1'b1, done_tick = 1'b0;
    logic [3:0] bcd2 = '0, bcd1 = '0, bcd0 = '0;
    logic [2:0] dp_in = '0;
    logic       start, valid, timeout_err;
    logic [7:0] seg_n;
    logic [2:0] an_n;

    int  n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
    int  start_cnt = 0, resp_cnt = 0, inj_req = 0, inj_done = 0;
    bit  resp_en = 1'b1;
    int  start_q[$];
    logic [10:0] disp_q[$];

    localparam logic [7:0] DASH = 8'b1_0111111;

    bcd_sseg_ctrl #(.SAMPLE_PERIOD(16), .REFRESH_DIV(4), .WAIT_TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .ready(ready), .done_tick(done_tick),
        .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .dp_in(dp_in),
        .start(start), .valid(valid), .timeout_err(timeout_err),
        .seg_n(seg_n), .an_n(an_n)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic int rel();
        return cyc - t0 - 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push3(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
        disp_q.push_back({3'b110, s0});
        disp_q.push_back({3'b101, s1});
        disp_q.push_back({3'b011, s2});
    endtask

    task automatic drain(input string nm, input int lim);
        int n = 0;
        while ((disp_q.size() != 0 || start_q.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (disp_q.size() != 0 || start_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d display / %0d start events still expected after %0d cycles",
                     nm, disp_q.size(), start_q.size(), lim);
            disp_q.delete();
            start_q.delete();
        end
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start && n < 100);
        chk(nm, start, 1);
    endtask

    // Converter model: answers each start 12 cycles later, or injects a stray done_tick on request
    initial forever begin
        @(negedge clk);
        if (inj_req != inj_done) begin
            done_tick = 1'b1;
            @(negedge clk);
            done_tick = 1'b0;
            inj_done++;
        end else if (start && resp_en) begin
            repeat (11) @(negedge clk);
            done_tick = 1'b1;
            @(negedge clk);
            done_tick = 1'b0;
            resp_cnt++;
        end
    end

    // Monitor: pops expected start cycles and display slots as the DUT presents them
    initial begin
        logic [2:0]  pan;
        logic        ps;
        bit          armed;
        int          es;
        logic [10:0] ed;
        pan = 3'b111;
        ps = 1'b0;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (start) begin
                start_cnt++;
                n_cmp++;
                if (ps) begin
                    n_err++;
                    $display("FAIL start_width: start high on consecutive cycles at rel %0d", rel());
                end
                if (start_q.size() != 0) begin
                    es = start_q.pop_front();
                    n_cmp++;
                    if (rel() != es) begin
                        n_err++;
                        $display("FAIL start_cycle: start at rel %0d want %0d", rel(), es);
                    end
                end
            end
            ps = start;
            if (an_n != pan && disp_q.size() != 0 && (armed || an_n == 3'b110)) begin
                ed = disp_q.pop_front();
                armed = disp_q.size() != 0;
                n_cmp++;
                if ({an_n, seg_n} !== ed) begin
                    n_err++;
                    $display("FAIL display: an_n/seg_n got %b/%b want %b/%b", an_n, seg_n, ed[10:8], ed[7:0]);
                end
            end
            pan = an_n;
        end
    end

    initial begin
        int s, base, r, n;
        dp_in = 3'b010;
        bcd2 = 4'd2; bcd1 = 4'd5; bcd0 = 4'd5;
        #2 reset = 1'b0;
        #1;
        chk("rst_start", start, 0);
        chk("rst_valid", valid, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_seg", seg_n, 8'hFF);
        chk("rst_an", an_n, 3'b111);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        t0 = cyc;

        // periodic starts at 16, 32, 48 with converter answering
        start_q.push_back(16);
        start_q.push_back(32);
        start_q.push_back(48);
        drain("t1_starts", 80);

        // capture 2,5,5 scanned with dp on tens
        while (rel() < 62) @(negedge clk);
        chk("t2_valid", valid, 1);
        push3(8'b1_0010010, 8'b0_0010010, 8'b1_0100100);
        drain("t2_scan", 40);

        // no done_tick: timeout after WAIT_TIMEOUT cycles, then recovery
        resp_en = 1'b0;
        wait_start("t4_start");
        repeat (31) @(negedge clk);
        chk("t4_tmo_early", timeout_err, 0);
        @(negedge clk);
        chk("t4_tmo", timeout_err, 1);
        chk("t4_valid_kept", valid, 1);
        @(negedge clk);
        chk("t4_back_idle", start, 1);
        push3(8'b1_0010010, 8'b0_0010010, 8'b1_0100100);
        drain("t4_old_digits", 40);
        dp_in = 3'b000;
        bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd7;
        resp_en = 1'b1;
        n = 0;
        while (timeout_err && n < 120) begin
            @(negedge clk);
            n++;
        end
        chk("t4_tmo_cleared", timeout_err, 0);
        chk("t4_valid", valid, 1);
        repeat (2) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
        push3(8'b1_1111000, 8'b1_1111111, 8'b1_1111111);
`else
        push3(8'b1_1111000, 8'b1_1000000, 8'b1_1000000);
`endif
        drain("t5_007", 40);

        // out-of-range hundreds digit shows a dash
        r = resp_cnt;
        bcd2 = 4'd12; bcd1 = 4'd3; bcd0 = 4'd4;
        n = 0;
        while (resp_cnt == r && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t5_resp", resp_cnt - r, 1);
        repeat (2) @(negedge clk);
        push3(8'b1_0011001, 8'b1_0110000, DASH);
        drain("t5_dash", 40);

        // ready low across wraps: one start on first ready cycle; stray done_tick in IDLE ignored
        wait_start("t3_sync");
        s = rel();
        ready = 1'b0;
        @(negedge clk);
        base = start_cnt;
        while (rel() < s + 20) @(negedge clk);
        bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9;
        inj_req++;
        repeat (3) @(negedge clk);
        bcd2 = 4'd12; bcd1 = 4'd3; bcd0 = 4'd4;
        push3(8'b1_0011001, 8'b1_0110000, DASH);
        drain("t3_idle_done_ignored", 30);
        while (rel() < s + 55) @(negedge clk);
        chk("t3_none_while_busy", start_cnt - base, 0);
        ready = 1'b1;
        start_q.push_back(s + 56);
        while (rel() < s + 68) @(negedge clk);
        chk("t3_one_start", start_cnt - base, 1);
        drain("t3_start", 5);

        // async reset mid-WAIT
        wait_start("t6_sync");
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_start", start, 0);
        chk("t6_valid", valid, 0);
        chk("t6_tmo", timeout_err, 0);
        chk("t6_seg", seg_n, 8'hFF);
        chk("t6_an", an_n, 3'b111);
        push3(DASH, DASH, DASH);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        t0 = cyc;
        start_q.push_back(16);
        repeat (3) @(negedge clk);
        chk("t6_valid_after", valid, 0);
        drain("t6_restart", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
